// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding, the widest supported operand, and a counter-width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 64;

    // Bits needed to count WIDTH serial steps (0..WIDTH-1); never below 1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// master = producer/consumer side, slave = the adder itself.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder cell used once per serial step.
module fa_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_ci,
    output logic o_sum,
    output logic o_co
);
    logic w_xy;

    assign w_xy  = i_x ^ i_y;
    assign o_sum = w_xy ^ i_ci;
    assign o_co  = (w_xy & i_ci) | (i_x & i_y);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures operands on an input handshake,
// adds LSB-first through a single full-adder cell over WIDTH cycles, then
// holds {cout,sum} until the output handshake completes.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("serial_adder: WIDTH=%0d outside 2..%0d", WIDTH, MAX_WIDTH);
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_bit_cnt;

    logic             w_fa_sum;
    logic             w_fa_co;
    logic             w_last_bit;

    // The cell always looks at the current LSBs; its result only matters in RUN.
    fa_cell u_fa (
        .i_x   (r_opa[0]),
        .i_y   (r_opb[0]),
        .i_ci  (r_carry),
        .o_sum (w_fa_sum),
        .o_co  (w_fa_co)
    );

    assign w_last_bit = (r_bit_cnt == CNT_W'(WIDTH - 1));

    // State register; reset wins over any handshake in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept -> WIDTH serial steps -> hold until consumed.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = RUN;
            RUN:     if (w_last_bit)    w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decode state only, so no input-to-output path exists.
    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        bus.busy      = (r_state == RUN) || (r_state == DONE);
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_carry;

    // Datapath: capture in IDLE, shift one bit per cycle in RUN, hold in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opa     <= '0;
            r_opb     <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_opa     <= bus.a;
                        r_opb     <= bus.b;
                        r_carry   <= bus.cin;
                        r_sum     <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
                    r_sum     <= {w_fa_sum, r_sum[WIDTH-1:1]};
                    r_opa     <= {1'b0, r_opa[WIDTH-1:1]};
                    r_opb     <= {1'b0, r_opb[WIDTH-1:1]};
                    r_carry   <= w_fa_co;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
                default: begin
                    // DONE: result registers hold until the consumer takes it.
                end
            endcase
        end
    end
endmodule
